frq_sel_scheduler: RTL and testbench

Controller that owns the 5-bit frequency-select code of the ROM-controlled frequency divider. It accepts one-shot select requests from a host port and runs an automatic sweep across a range of select codes. All requests pass through a single pending slot. A new code reaches the divider only on the divider's period-boundary tick, so the divided clock never sees a mid-period code change.

---
 rtl/frq_sel_scheduler.sv | 152 +++++++++++++++
 tb/tb_frq_sel_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frq_sel_scheduler.sv
// Owns the divider frequency-select code: host one-shot requests and automatic
// sweeps share one pending slot that is committed only on a divider period tick.
module frq_sel_scheduler #(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               host_valid,
    input  logic [SEL_W-1:0]   host_sel,
    output logic               host_ready,
    input  logic               sweep_en,
    input  logic [SEL_W-1:0]   sweep_start,
    input  logic [SEL_W-1:0]   sweep_end,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               div_tick,
    output logic [SEL_W-1:0]   f_select,
    output logic               applied,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic {IDLE, PEND} state_t;
    typedef enum logic {SRC_HOST, SRC_SWEEP} src_t;

    state_t             state, state_nxt;
    src_t               pend_src, pend_src_nxt;
    logic [SEL_W-1:0]   pend_sel, pend_sel_nxt;

    logic               en_d, en_rise, en_fall;
    logic               sweep_active, sweep_req, sweep_up;
    logic [SEL_W-1:0]   sweep_cur, sweep_last;
    logic [DWELL_W-1:0] dwell_ld, dwell_cnt;

    logic               host_acc, sweep_take, do_apply, do_abort;

    always_comb begin
        en_rise    = sweep_en & ~en_d;
        en_fall    = ~sweep_en & en_d;
        host_acc   = (state == IDLE) && host_valid && host_ready;
        // A sweep request is taken the same cycle the enable rises.
        sweep_take = (state == IDLE) && !host_acc && !en_fall &&
                     (en_rise || (sweep_req && sweep_active));
        do_abort   = (state == PEND) && (pend_src == SRC_SWEEP) && en_fall;
        do_apply   = (state == PEND) && div_tick && !do_abort;
    end

    always_comb begin
        state_nxt    = state;
        pend_sel_nxt = pend_sel;
        pend_src_nxt = pend_src;
        case (state)
            IDLE: begin
                if (host_acc) begin
                    state_nxt    = PEND;
                    pend_sel_nxt = host_sel;
                    pend_src_nxt = SRC_HOST;
                end else if (sweep_take) begin
                    state_nxt    = PEND;
                    pend_sel_nxt = en_rise ? sweep_start : sweep_cur;
                    pend_src_nxt = SRC_SWEEP;
                end
            end
            PEND: begin
                if (do_abort || do_apply)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pend_sel <= '0;
            pend_src <= SRC_HOST;
        end else begin
            state    <= state_nxt;
            pend_sel <= pend_sel_nxt;
            pend_src <= pend_src_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_select   <= '0;
            applied    <= 1'b0;
            host_ready <= 1'b0;
        end else begin
            applied    <= do_apply;
            host_ready <= (state_nxt == IDLE);
            if (do_apply)
                f_select <= pend_sel;
        end
    end

    // Sweep engine; dwell_cnt != 0 marks "dwelling on an applied sweep code".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_d         <= 1'b0;
            sweep_active <= 1'b0;
            sweep_req    <= 1'b0;
            sweep_up     <= 1'b0;
            sweep_cur    <= '0;
            sweep_last   <= '0;
            dwell_ld     <= '0;
            dwell_cnt    <= '0;
            sweep_done   <= 1'b0;
        end else begin
            en_d       <= sweep_en;
            sweep_done <= 1'b0;
            if (host_acc) begin
                sweep_active <= 1'b0;
                sweep_req    <= 1'b0;
                dwell_cnt    <= '0;
            end else if (en_rise) begin
                sweep_active <= 1'b1;
                sweep_cur    <= sweep_start;
                sweep_last   <= sweep_end;
                sweep_up     <= (sweep_end > sweep_start);
                dwell_ld     <= (dwell == '0) ? DWELL_W'(1) : dwell;
                dwell_cnt    <= '0;
                sweep_req    <= !sweep_take;
            end else if (en_fall) begin
                sweep_active <= 1'b0;
                sweep_req    <= 1'b0;
                dwell_cnt    <= '0;
            end else begin
                if (sweep_take)
                    sweep_req <= 1'b0;
                if (do_apply && pend_src == SRC_SWEEP && sweep_active) begin
                    dwell_cnt <= dwell_ld;
                end else if (div_tick && dwell_cnt != '0) begin
                    dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    if (dwell_cnt == DWELL_W'(1)) begin
                        if (sweep_cur == sweep_last) begin
                            sweep_done   <= sweep_active;
                            sweep_active <= 1'b0;
                        end else begin
                            sweep_cur <= sweep_up ? sweep_cur + SEL_W'(1)
                                                  : sweep_cur - SEL_W'(1);
                            sweep_req <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE) || sweep_active;

endmodule

// File: tb/tb_frq_sel_scheduler.sv
// Randomized bench for frq_sel_scheduler; sweeps are checked against a
// tick-level model (expected code list, tick spacing, done position).
module tb_frq_sel_scheduler;
    localparam int SEL_W   = 5;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               host_valid = 1'b0;
    logic [SEL_W-1:0]   host_sel = '0;
    logic               host_ready;
    logic               sweep_en = 1'b0;
    logic [SEL_W-1:0]   sweep_start = '0;
    logic [SEL_W-1:0]   sweep_end = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               div_tick;
    logic [SEL_W-1:0]   f_select;
    logic               applied;
    logic               busy;
    logic               sweep_done;

    logic man_tick = 1'b0, gen_tick = 1'b0, auto_tick = 1'b0;
    int   tick_period = 4;
    int   n_chk = 0, n_err = 0;

    int tick_idx = 0;
    int app_code[$];
    int app_tick[$];
    int done_tick[$];

    assign div_tick = auto_tick ? gen_tick : man_tick;

    frq_sel_scheduler #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_sel(host_sel), .host_ready(host_ready),
        .sweep_en(sweep_en), .sweep_start(sweep_start), .sweep_end(sweep_end),
        .dwell(dwell), .div_tick(div_tick),
        .f_select(f_select), .applied(applied), .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            if (auto_tick) begin
                c++;
                if (c >= tick_period) begin c = 0; gen_tick = 1'b1; end
                else gen_tick = 1'b0;
            end else begin
                c = 0;
                gen_tick = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (div_tick) tick_idx++;
            if (applied) begin
                app_code.push_back(int'(f_select));
                app_tick.push_back(tick_idx);
            end
            if (sweep_done) done_tick.push_back(tick_idx);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        app_code.delete();
        app_tick.delete();
        done_tick.delete();
    endtask

    task automatic wait_ready();
        int b = 40;
        while (!host_ready && b > 0) begin @(negedge clk); b--; end
        chk("host_ready_wait", 32'(b > 0), 1);
    endtask

    // Host request with a tick on the acceptance edge, then a tick d cycles later.
    task automatic host_apply(input int c, input int d);
        wait_ready();
        host_valid = 1'b1; host_sel = SEL_W'(c); man_tick = 1'b1;
        @(posedge clk); #1;
        chk("host_tick_on_accept", 32'(applied), 0);
        chk("host_busy_pend", 32'(busy), 1);
        chk("host_ready_drop", 32'(host_ready), 0);
        @(negedge clk); host_valid = 1'b0; man_tick = 1'b0;
        repeat (d - 1) @(negedge clk);
        man_tick = 1'b1;
        @(posedge clk); #1;
        chk("host_applied", 32'(applied), 1);
        chk("host_fsel", 32'(f_select), 32'(c));
        @(negedge clk); man_tick = 1'b0;
        @(posedge clk); #1;
        chk("host_single_pulse", 32'(applied), 0);
        chk("host_ready_back", 32'(host_ready), 1);
        chk("host_busy_idle", 32'(busy), 0);
        @(negedge clk);
    endtask

    task automatic run_sweep(input int s, input int e, input int dw, input int per);
        int codes[$];
        int d1 = (dw == 0) ? 1 : dw;
        int v = s;
        int budget;
        forever begin
            codes.push_back(v);
            if (v == e) break;
            v += (e > s) ? 1 : -1;
        end
        clear_mon();
        tick_period = per;
        auto_tick = 1'b1;
        sweep_start = SEL_W'(s); sweep_end = SEL_W'(e); dwell = DWELL_W'(dw);
        sweep_en = 1'b1;
        budget = (codes.size() * (d1 + 1) + 4) * per + 20;
        while (done_tick.size() == 0 && budget > 0) begin @(negedge clk); budget--; end
        chk("swp_timeout", 32'(budget > 0), 1);
        repeat (3 * per) @(negedge clk);
        chk("swp_n_apply", 32'(app_code.size()), 32'(codes.size()));
        for (int i = 0; i < codes.size(); i++) begin
            if (i < app_code.size()) begin
                chk("swp_code", 32'(app_code[i]), 32'(codes[i]));
                if (i > 0) chk("swp_spacing", 32'(app_tick[i] - app_tick[i-1]), 32'(d1 + 1));
            end
        end
        chk("swp_done_cnt", 32'(done_tick.size()), 1);
        if (done_tick.size() > 0 && app_tick.size() > 0)
            chk("swp_done_pos", 32'(done_tick[0] - app_tick[app_tick.size()-1]), 32'(d1));
        chk("swp_busy_end", 32'(busy), 0);
        chk("swp_fsel_end", 32'(f_select), 32'(e));
        sweep_en = 1'b0; auto_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, n, s, e, span;
        // reset state
        #12;
        chk("rst_fsel", 32'(f_select), 0);
        chk("rst_applied", 32'(applied), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(sweep_done), 0);
        chk("rst_ready", 32'(host_ready), 0);
        @(negedge clk); reset = 1'b0;
        chk("rst_ready_pre_edge", 32'(host_ready), 0);
        @(posedge clk); #1;
        chk("rst_ready_post_edge", 32'(host_ready), 1);
        @(negedge clk);

        // host applies
        host_apply(7, 5);
        host_apply(1, 1);
        for (int k = 0; k < 6; k++)
            host_apply(int'($urandom_range(31)), int'($urandom_range(5, 1)));

        // directed sweeps
        run_sweep(3, 5, 2, 4);
        run_sweep(6, 4, 0, 4);
        run_sweep(9, 9, 1, 3);
        // random sweeps
        for (int k = 0; k < 5; k++) begin
            s = int'($urandom_range(31));
            span = int'($urandom_range(4));
            e = ($urandom_range(1) == 1) ? s + span : s - span;
            if (e > 31) e = 31;
            if (e < 0) e = 0;
            run_sweep(s, e, int'($urandom_range(3)), int'($urandom_range(6, 3)));
        end

        // host override mid-sweep
        clear_mon();
        tick_period = 4; auto_tick = 1'b1;
        sweep_start = 5'd3; sweep_end = 5'd8; dwell = 16'd2; sweep_en = 1'b1;
        b = 300;
        while (!(app_code.size() > 0 && app_code[app_code.size()-1] == 4) && b > 0) begin
            @(negedge clk); b--;
        end
        chk("ovr_reach4", 32'(b > 0), 1);
        wait_ready();
        host_valid = 1'b1; host_sel = 5'd20;
        @(negedge clk); host_valid = 1'b0;
        n = app_code.size();
        repeat (30) @(negedge clk);
        chk("ovr_n_apply", 32'(app_code.size()), 32'(n + 1));
        if (app_code.size() > n) chk("ovr_code", 32'(app_code[n]), 20);
        chk("ovr_no_done", 32'(done_tick.size()), 0);
        chk("ovr_fsel", 32'(f_select), 20);
        chk("ovr_busy", 32'(busy), 0);
        sweep_en = 1'b0; auto_tick = 1'b0;
        repeat (2) @(negedge clk);

        // abort while a sweep code is pending
        clear_mon();
        sweep_start = 5'd10; sweep_end = 5'd12; dwell = 16'd1; sweep_en = 1'b1;
        @(posedge clk); #1;
        chk("abt_busy_pend", 32'(busy), 1);
        chk("abt_ready_pend", 32'(host_ready), 0);
        @(negedge clk); sweep_en = 1'b0;
        @(posedge clk); #1;
        chk("abt_busy_idle", 32'(busy), 0);
        chk("abt_ready_idle", 32'(host_ready), 1);
        @(negedge clk); man_tick = 1'b1;
        @(posedge clk); #1;
        chk("abt_no_apply", 32'(applied), 0);
        chk("abt_fsel_hold", 32'(f_select), 20);
        @(negedge clk); man_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("abt_n_apply", 32'(app_code.size()), 0);
        chk("abt_no_done", 32'(done_tick.size()), 0);

        // asynchronous reset with a host code pending
        wait_ready();
        host_valid = 1'b1; host_sel = 5'd9;
        @(negedge clk); host_valid = 1'b0;
        chk("arst_busy_before", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_fsel", 32'(f_select), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_applied", 32'(applied), 0);
        chk("arst_ready", 32'(host_ready), 0);
        @(negedge clk); reset = 1'b0;
        chk("arst_ready_pre_edge", 32'(host_ready), 0);
        @(posedge clk); #1;
        chk("arst_ready_post_edge", 32'(host_ready), 1);
        @(negedge clk); man_tick = 1'b1;
        @(posedge clk); #1;
        chk("arst_discarded", 32'(applied), 0);
        chk("arst_fsel_zero", 32'(f_select), 0);
        @(negedge clk); man_tick = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
